// File: rtl/store_write_buffer.sv
// Posted-write buffer between the CPU memory stage and a single-port data memory.
// Define WB_COALESCE_EN to merge a store into the youngest entry when the addresses match.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_wr_valid,
    output logic                   cpu_wr_ready,
    input  logic [AW-1:0]          cpu_wr_addr,
    input  logic [DW-1:0]          cpu_wr_data,
    input  logic                   cpu_rd_en,
    input  logic [AW-1:0]          cpu_rd_addr,
    output logic [DW-1:0]          cpu_rd_data,
    input  logic                   flush,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, head_d, tail_d, youngest;
    logic [CW-1:0] count_q, count_d;
    logic          full, push, alloc, coalesce, pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign youngest = tail_q - PW'(1);

`ifdef WB_COALESCE_EN
    // Never merge into the head while it is leaving for DM this cycle.
    assign coalesce     = !empty && (addr_q[youngest] == cpu_wr_addr) &&
                          !((youngest == head_q) && mem_write);
    assign cpu_wr_ready = !flush && (!full || coalesce);
`else
    assign coalesce     = 1'b0;
    assign cpu_wr_ready = !flush && !full;
`endif

    assign push  = cpu_wr_valid && cpu_wr_ready;
    assign alloc = push && !coalesce;
    assign pop   = mem_write;

    // A load owns the shared DM port, so draining waits.
    assign mem_write = !empty && !cpu_rd_en;
    assign mem_read  = cpu_rd_en;
    assign mem_addr  = cpu_rd_en ? cpu_rd_addr : addr_q[head_q];
    assign mem_wdata = data_q[head_q];

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        cpu_rd_data = mem_rdata;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == cpu_rd_addr)) begin
                cpu_rd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (alloc) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(alloc) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alloc) begin
                addr_q[tail_q] <= cpu_wr_addr;
                data_q[tail_q] <= cpu_wr_data;
            end else if (push) begin
                data_q[youngest] <= cpu_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized bench for store_write_buffer against a queue-based reference model.
// Honors WB_COALESCE_EN the same way the design does.
module tb_store_write_buffer;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_valid, cpu_wr_ready;
    logic [31:0] cpu_wr_addr, cpu_wr_data;
    logic        cpu_rd_en;
    logic [31:0] cpu_rd_addr, cpu_rd_data;
    logic        flush;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;
    logic [2:0]  count;
    logic        empty;

    logic        dm_load;
    logic [31:0] dm [16];
    logic [31:0] ref_dm [16];
    ent_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_rd_addr  (cpu_rd_addr),
        .cpu_rd_data  (cpu_rd_data),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .count        (count),
        .empty        (empty)
    );

    // Data memory: combinational read, write on posedge.
    assign mem_rdata = dm[mem_addr[3:0]];
    always @(posedge clk) begin
        if (dm_load) begin
            for (int i = 0; i < 16; i++) dm[i] <= 32'h1000 + i;
        end else if (mem_write) begin
            dm[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] wa, input logic [31:0] wd,
                        input logic re, input logic [31:0] ra, input logic fl);
        int          n;
        logic        coal, exp_rdy, exp_mw;
        logic [31:0] exp_rd;
        @(negedge clk);
        cpu_wr_valid = v;
        cpu_wr_addr  = wa;
        cpu_wr_data  = wd;
        cpu_rd_en    = re;
        cpu_rd_addr  = ra;
        flush        = fl;
        #1;
        n      = q.size();
        exp_mw = (n > 0) && !re;
        coal   = 1'b0;
`ifdef WB_COALESCE_EN
        if (n > 0 && q[n-1].addr == wa && !(n == 1 && exp_mw)) coal = 1'b1;
`endif
        exp_rdy = !fl && ((n != DEPTH) || coal);
        exp_rd  = ref_dm[ra[3:0]];
        for (int i = 0; i < n; i++) if (q[i].addr == ra) exp_rd = q[i].data;
        check_eq("count", count, n);
        check_eq("empty", empty, n == 0);
        check_eq("wr_ready", cpu_wr_ready, exp_rdy);
        check_eq("mem_write", mem_write, exp_mw);
        check_eq("mem_read", mem_read, re);
        if (re) begin
            check_eq("ld_addr", mem_addr, ra);
            check_eq("rd_data", cpu_rd_data, exp_rd);
        end else if (exp_mw) begin
            check_eq("drain_addr", mem_addr, q[0].addr);
            check_eq("drain_data", mem_wdata, q[0].data);
        end
        @(posedge clk);
        #1;
        if (v && exp_rdy) begin
            if (coal) q[n-1].data = wd;
            else q.push_back('{addr: wa, data: wd});
        end
        if (exp_mw) begin
            ref_dm[q[0].addr[3:0]] = q[0].data;
            void'(q.pop_front());
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        dm_load = 1'b1;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        cpu_rd_en = 1'b0;
        cpu_rd_addr = '0;
        flush = 1'b0;
        for (int i = 0; i < 16; i++) ref_dm[i] = 32'h1000 + i;
        @(posedge clk);
        #1;
        dm_load = 1'b0;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_ready", cpu_wr_ready, 1);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single store drains on the next edge.
        step(1'b1, 5, 32'hAA, 1'b0, 0, 1'b0);
        check_eq("t1_count1", count, 1);
        step(1'b0, 0, 0, 1'b0, 0, 1'b0);
        check_eq("t1_count0", count, 0);
        check_eq("t1_dm5", dm[5], 32'hAA);

        // Fill while loads starve the drain, then release.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 32'h100 + i, 1'b1, 0, 1'b0);
        check_eq("t2_full_count", count, 4);
        check_eq("t2_full_ready", cpu_wr_ready, 0);
        step(1'b1, 9, 32'h109, 1'b1, 0, 1'b0);
        check_eq("t2_refused", count, 4);
        idle(4);
        for (int i = 1; i <= 4; i++) check_eq("t2_dm", dm[i], 32'h100 + i);

        // Forwarding from the youngest match, and miss falls through to DM.
        step(1'b1, 7, 32'h11, 1'b1, 0, 1'b0);
        step(1'b1, 7, 32'h22, 1'b1, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 7, 1'b0);
        check_eq("t3_fwd7", cpu_rd_data, 32'h22);
        step(1'b0, 0, 0, 1'b1, 8, 1'b0);
        check_eq("t3_miss8", cpu_rd_data, 32'h1008);
        idle(3);

        // Pointer wrap with one push and one drain per cycle.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i % 16, 32'h200 + i, 1'b0, 0, 1'b0);
            check_eq("t4_cnt_le2", count <= 2, 1);
        end
        idle(2);

        // Asynchronous reset with entries pending and a drain about to happen.
        for (int i = 10; i <= 12; i++) step(1'b1, i, 32'h300 + i, 1'b1, 0, 1'b0);
        @(negedge clk);
        cpu_wr_valid = 1'b0;
        cpu_rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_count", count, 0);
        check_eq("t5_empty", empty, 1);
        check_eq("t5_mem_write", mem_write, 0);
        check_eq("t5_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        q.delete();
        for (int i = 10; i <= 12; i++) check_eq("t5_dm_kept", dm[i], ref_dm[i]);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Same-address pushes with the drain stalled.
        step(1'b1, 3, 32'h01, 1'b1, 0, 1'b0);
        step(1'b1, 3, 32'h02, 1'b1, 0, 1'b0);
`ifdef WB_COALESCE_EN
        check_eq("t6_count", count, 1);
`else
        check_eq("t6_count", count, 2);
`endif
        idle(3);
        check_eq("t6_dm3", dm[3], 32'h02);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 100) < 60, $urandom % 8, $urandom, ($urandom % 100) < 45,
                 $urandom % 10, ($urandom % 8) == 0);
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) idle(1);
        check_eq("final_empty", q.size(), 0);
        for (int i = 0; i < 16; i++) check_eq("final_dm", dm[i], ref_dm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
